csr_timer: RTL and testbench
============================

Name: csr_timer

Overview:
- Timer and counter CSR unit next to the CSR file.
- Implements TID, TCFG, TVAL and TICLR, plus a 64-bit stable counter for RDCNTV{L,H}.W and RDCNTID.
- Produces the timer-interrupt pending bit that drives ESTAT.IS[11].
- Shares the CSR write port and read index with the CSR file; the writeback-stage CSR read mux ORs `timer_rval` into the CSR read data when `timer_hit`.

Parameters:
- TIMER_W, 32: implemented width of TVAL and TCFG.InitVal field; legal 3..32.
- CORE_ID, 32'h0: reset value of TID.

Ports:
- clk, input, 1: clock.
- resetn, input, 1: reset.
- csr_we, input, 1: CSR write strobe (already qualified by the pipeline).
- csr_wnum, input, 14: CSR write index.
- csr_wmask, input, 32: per-bit write mask.
- csr_wval, input, 32: write data.
- csr_rnum, input, 14: CSR read index.
- timer_rval, output, 32: read data for TID/TCFG/TVAL/TICLR; 0 otherwise.
- timer_hit, output, 1: csr_rnum is 0x40, 0x41, 0x42 or 0x44.
- timer_int, output, 1: TI pending; to CSR ESTAT.IS[11].
- stable_cnt, output, 64: free-running counter for RDCNTV*.
- core_id, output, 32: current TID for RDCNTID.

Interface decision: one clock `clk`; reset `resetn` is asynchronous and active-low. All state clears on `resetn`=0 irrespective of `clk`.

Behaviour:
- Addresses: TID=0x40, TCFG=0x41, TVAL=0x42, TICLR=0x44. A write updates a register as `(wmask & wval) | (~wmask & old)`, only when `csr_we` and `csr_wnum` match.
- Reset values:
  - TID = CORE_ID.
  - TCFG = 0 (En=0, Periodic=0, InitVal=0).
  - TVAL = 0.
  - TI = 0.
  - stable_cnt = 0.
  - Outputs follow from these reset values.
- TCFG layout:
  - bit0 En, bit1 Periodic, bits[TIMER_W-1:2] InitVal.
  - Upper bits are read as 0 and not stored.
  - The TCFG read value is the stored value.
- TVAL:
  - Read-only; software writes to 0x42 are ignored.
  - The read value is zero-extended to 32 bits.
- TCFG write cycle N:
  - TVAL = {new InitVal, 2'b00} at N+1 (uses the masked-merged new value).
  - The first decrement happens at N+2 if the new En=1.
  - The TCFG write overrides any decrement or reload in cycle N.
- Countdown, each cycle with En=1 and no TCFG write:
  - TVAL==0 and Periodic=1: TVAL <= {InitVal, 2'b00}, and TI <= 1.
  - TVAL==0 and Periodic=0: TVAL <= all-ones, and TI <= 1. The one-shot then stops.
  - TVAL == all-ones and Periodic=0: hold; no further TI.
  - Otherwise: TVAL <= TVAL-1.
- En=0: TVAL holds and TI is never set.
- Periodic with InitVal=0: TI is set every cycle (legal, no special casing).
- TICLR:
  - A write with `wmask[0] & wval[0]` clears TI at the next edge.
  - Reads return 0 and there is no storage.
  - If a set and a clear land in the same cycle, the set wins and TI stays 1, so the event is not lost.
- timer_int = TI (registered). There is no combinational path from write inputs to timer_int.
- stable_cnt:
  - Increments by 1 every cycle and wraps 2^64-1 -> 0.
  - It is not writable and never stalls.
- timer_rval and timer_hit are purely combinational from `csr_rnum` and current state. A read in the same cycle as a write returns the old value.
- Asserting resetn mid-countdown immediately zeroes TVAL/TCFG/TI; the counter restarts only after software rewrites TCFG.

Test Plan:
- Reset deasserted, no writes for 100 cycles -> timer_int=0, TVAL=0, stable_cnt=100, core_id=CORE_ID.
- Write TCFG=0x0000_0011 (InitVal=4, En=1, one-shot) at cycle N:
  - TVAL reads 16 at N+1 and 15 at N+2.
  - TI=1 at the edge after TVAL==0 (N+18).
  - TVAL then stays 0xFFFF_FFFF; TI is not re-set after being cleared by TICLR=1.
- Write TCFG=0x0000_000B (InitVal=2, Periodic, En):
  - TVAL sequence 8, 7, ..., 0, 8, ...
  - TI re-asserts every 9 cycles after each TICLR clear.
- Write TICLR=1 in the same cycle TVAL==0 with En=1 -> TI remains 1. Write TICLR=1 one cycle later -> TI=0.
- Masked write to TCFG with wmask=0x1, wval=0 mid-count -> En=0, TVAL reloads to {InitVal,00} and then holds; a write to TVAL (0x42) has no effect.
- Pull resetn low between clock edges mid-count -> TVAL, TCFG and TI read 0 immediately and stable_cnt=0.

Source files
------------

// File: rtl/csr_timer_if.sv
// -----------------------------------------------------------------------------
// csr_timer_if
// Shared CSR access bundle between the CSR file side (master) and the timer
// CSR unit (slave).
//   csr_we     : write strobe, already qualified by the pipeline
//   csr_wnum   : 14-bit CSR write index
//   csr_wmask  : per-bit write mask
//   csr_wval   : write data
//   csr_rnum   : 14-bit CSR read index
//   timer_rval : read data from the timer unit (0 when not addressed)
//   timer_hit  : csr_rnum selects one of the timer CSRs
// -----------------------------------------------------------------------------
interface csr_timer_if;
   logic        csr_we;
   logic [13:0] csr_wnum;
   logic [31:0] csr_wmask;
   logic [31:0] csr_wval;
   logic [13:0] csr_rnum;
   logic [31:0] timer_rval;
   logic        timer_hit;

   modport master (
      output csr_we, csr_wnum, csr_wmask, csr_wval, csr_rnum,
      input  timer_rval, timer_hit
   );

   modport slave (
      input  csr_we, csr_wnum, csr_wmask, csr_wval, csr_rnum,
      output timer_rval, timer_hit
   );
endinterface

// File: rtl/csr_timer.sv
// -----------------------------------------------------------------------------
// csr_timer
// Timer/counter CSR unit: TID (0x40), TCFG (0x41), TVAL (0x42, read-only),
// TICLR (0x44, write-only), the timer-interrupt pending bit and a 64-bit
// free-running stable counter.
// Ports:
//   clk        : clock
//   resetn     : asynchronous active-low reset
//   bus        : CSR write port / read index and read data (slave modport)
//   timer_int  : registered TI pending bit, feeds ESTAT.IS[11]
//   stable_cnt : free-running 64-bit counter for RDCNTV{L,H}.W
//   core_id    : current TID value for RDCNTID
// Parameters:
//   TIMER_W    : width of TVAL and of TCFG storage (3..32)
//   CORE_ID    : reset value of TID
// -----------------------------------------------------------------------------
module csr_timer #(
   parameter int          TIMER_W = 32,
   parameter logic [31:0] CORE_ID = 32'h0
) (
   input  logic        clk,
   input  logic        resetn,
   csr_timer_if.slave  bus,
   output logic        timer_int,
   output logic [63:0] stable_cnt,
   output logic [31:0] core_id
);

   localparam logic [13:0] ADDR_TID   = 14'h40;
   localparam logic [13:0] ADDR_TCFG  = 14'h41;
   localparam logic [13:0] ADDR_TVAL  = 14'h42;
   localparam logic [13:0] ADDR_TICLR = 14'h44;

   localparam logic [TIMER_W-1:0] TVAL_ONE = {{(TIMER_W-1){1'b0}}, 1'b1};

   logic [31:0]        tid_q,  tid_d;
   logic [TIMER_W-1:0] tcfg_q, tcfg_d;
   logic [TIMER_W-1:0] tval_q, tval_d;
   logic               ti_q,   ti_d;
   logic [63:0]        cnt_q,  cnt_d;

   logic               wr_tid, wr_tcfg, wr_ticlr;
   logic [31:0]        tcfg_ext, tval_ext;
   logic [31:0]        tid_merged, tcfg_merged;
   logic [TIMER_W-1:0] reload_val;
   logic               tcfg_en, tcfg_periodic;
   logic               ti_set, ti_clr;

   assign wr_tid   = bus.csr_we && (bus.csr_wnum == ADDR_TID);
   assign wr_tcfg  = bus.csr_we && (bus.csr_wnum == ADDR_TCFG);
   assign wr_ticlr = bus.csr_we && (bus.csr_wnum == ADDR_TICLR);

   // Stored TCFG/TVAL are TIMER_W wide; upper bits read back as zero.
   assign tcfg_ext = 32'(tcfg_q);
   assign tval_ext = 32'(tval_q);

   assign tid_merged  = (bus.csr_wmask & bus.csr_wval) | (~bus.csr_wmask & tid_q);
   assign tcfg_merged = (bus.csr_wmask & bus.csr_wval) | (~bus.csr_wmask & tcfg_ext);

   assign tcfg_en       = tcfg_q[0];
   assign tcfg_periodic = tcfg_q[1];
   assign reload_val    = {tcfg_q[TIMER_W-1:2], 2'b00};

   assign ti_clr = wr_ticlr && bus.csr_wmask[0] && bus.csr_wval[0];

   always_comb begin
      tid_d  = tid_q;
      tcfg_d = tcfg_q;
      tval_d = tval_q;
      ti_set = 1'b0;

      if (wr_tid) begin
         tid_d = tid_merged;
      end

      // A TCFG write loads TVAL from the freshly merged InitVal and takes
      // priority over whatever the countdown would have done this cycle.
      if (wr_tcfg) begin
         tcfg_d = tcfg_merged[TIMER_W-1:0];
         tval_d = {tcfg_merged[TIMER_W-1:2], 2'b00};
      end else if (tcfg_en) begin
         if (tval_q == '0) begin
            ti_set = 1'b1;
            // One-shot parks at all-ones, which the next branch then holds.
            tval_d = tcfg_periodic ? reload_val : '1;
         end else if ((tval_q == '1) && !tcfg_periodic) begin
            tval_d = tval_q;
         end else begin
            tval_d = tval_q - TVAL_ONE;
         end
      end

      // Set beats clear so a timer event landing with a TICLR is not lost.
      if (ti_set) begin
         ti_d = 1'b1;
      end else if (ti_clr) begin
         ti_d = 1'b0;
      end else begin
         ti_d = ti_q;
      end

      cnt_d = cnt_q + 64'd1;
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         tid_q  <= CORE_ID;
         tcfg_q <= '0;
         tval_q <= '0;
         ti_q   <= 1'b0;
         cnt_q  <= '0;
      end else begin
         tid_q  <= tid_d;
         tcfg_q <= tcfg_d;
         tval_q <= tval_d;
         ti_q   <= ti_d;
         cnt_q  <= cnt_d;
      end
   end

   // Read side is purely combinational on current state, so a read in the
   // same cycle as a write observes the old value.
   always_comb begin
      bus.timer_rval = 32'h0;
      bus.timer_hit  = 1'b0;
      case (bus.csr_rnum)
         ADDR_TID: begin
            bus.timer_rval = tid_q;
            bus.timer_hit  = 1'b1;
         end
         ADDR_TCFG: begin
            bus.timer_rval = tcfg_ext;
            bus.timer_hit  = 1'b1;
         end
         ADDR_TVAL: begin
            bus.timer_rval = tval_ext;
            bus.timer_hit  = 1'b1;
         end
         ADDR_TICLR: begin
            bus.timer_rval = 32'h0;
            bus.timer_hit  = 1'b1;
         end
         default: begin
            bus.timer_rval = 32'h0;
            bus.timer_hit  = 1'b0;
         end
      endcase
   end

   assign timer_int  = ti_q;
   assign stable_cnt = cnt_q;
   assign core_id    = tid_q;

endmodule

// File: tb/tb_csr_timer.sv
// -----------------------------------------------------------------------------
// tb_csr_timer
// Directed scoreboard bench for csr_timer. Stimulus drives CSR writes and
// read probes, pushing hand-computed expectations into a queue; a monitor on
// the falling edge pops and compares whenever a probe is presented.
// -----------------------------------------------------------------------------
module tb_csr_timer;

   localparam logic [31:0] CID = 32'h1234_5678;
   localparam logic [31:0] TID_NEW = 32'hABCD_5678;

   logic        clk = 1'b0;
   logic        resetn;
   logic        timer_int;
   logic [63:0] stable_cnt;
   logic [31:0] core_id;

   csr_timer_if tif();

   csr_timer #(
      .TIMER_W (32),
      .CORE_ID (CID)
   ) dut (
      .clk        (clk),
      .resetn     (resetn),
      .bus        (tif),
      .timer_int  (timer_int),
      .stable_cnt (stable_cnt),
      .core_id    (core_id)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] rval;
      logic        hit;
      logic        ti;
      logic [63:0] cnt;
      logic [31:0] id;
   } exp_t;

   exp_t        exp_q[$];
   string       nm_q[$];
   int          checks   = 0;
   int          failures = 0;
   logic        probe_v  = 1'b0;
   logic [63:0] exp_cnt  = 64'd0;
   exp_t        mon_e;
   string       mon_n;

   task automatic cmp(input string nm, input string fld,
                      input logic [63:0] act, input logic [63:0] expv);
      checks++;
      if (act !== expv) begin
         failures++;
         $display("FAIL %s.%s actual=0x%0h required=0x%0h", nm, fld, act, expv);
      end
   endtask

   // Monitor: consumes one expectation per presented probe.
   always @(negedge clk) begin
      if (probe_v) begin
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL monitor probe with empty expectation queue");
         end else begin
            mon_e = exp_q.pop_front();
            mon_n = nm_q.pop_front();
            $display("probe %-14s rnum=0x%0h rval=0x%08h hit=%0b ti=%0b cnt=%0d id=0x%08h",
                     mon_n, tif.csr_rnum, tif.timer_rval, tif.timer_hit,
                     timer_int, stable_cnt, core_id);
            cmp(mon_n, "rval", 64'(tif.timer_rval), 64'(mon_e.rval));
            cmp(mon_n, "hit",  64'(tif.timer_hit),  64'(mon_e.hit));
            cmp(mon_n, "ti",   64'(timer_int),      64'(mon_e.ti));
            cmp(mon_n, "cnt",  stable_cnt,          mon_e.cnt);
            cmp(mon_n, "id",   64'(core_id),        64'(mon_e.id));
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
      if (resetn) exp_cnt++;
   endtask

   task automatic probe(input string nm, input logic [13:0] rn,
                        input logic [31:0] rv, input logic hit,
                        input logic ti, input logic [31:0] id);
      exp_t e;
      e.rval = rv;
      e.hit  = hit;
      e.ti   = ti;
      e.cnt  = exp_cnt;
      e.id   = id;
      tif.csr_rnum = rn;
      exp_q.push_back(e);
      nm_q.push_back(nm);
      probe_v = 1'b1;
      @(negedge clk);
      #1;
      probe_v = 1'b0;
   endtask

   task automatic set_wr(input logic [13:0] a, input logic [31:0] m,
                         input logic [31:0] v);
      tif.csr_we    = 1'b1;
      tif.csr_wnum  = a;
      tif.csr_wmask = m;
      tif.csr_wval  = v;
   endtask

   task automatic tick_w();
      tick();
      tif.csr_we = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog time limit expired");
      $fatal(1, "watchdog");
   end

   initial begin
      resetn        = 1'b0;
      tif.csr_we    = 1'b0;
      tif.csr_wnum  = '0;
      tif.csr_wmask = '0;
      tif.csr_wval  = '0;
      tif.csr_rnum  = '0;

      // Reset state
      tick(); tick();
      probe("rst_tcfg", 14'h41, 32'h0, 1'b1, 1'b0, CID);
      resetn = 1'b1;

      // 100 idle cycles
      repeat (100) tick();
      probe("idle_tval", 14'h42, 32'h0, 1'b1, 1'b0, CID);
      tick();
      probe("nohit_43", 14'h43, 32'h0, 1'b0, 1'b0, CID);
      tick();
      probe("ticlr_rd", 14'h44, 32'h0, 1'b1, 1'b0, CID);
      tick();

      // One-shot, InitVal=4
      set_wr(14'h41, 32'hFFFF_FFFF, 32'h11);
      probe("tcfg_old", 14'h41, 32'h0, 1'b1, 1'b0, CID);
      tick_w();                                           // N+1
      probe("os_n1", 14'h42, 32'd16, 1'b1, 1'b0, CID);
      tick();                                             // N+2
      probe("os_n2", 14'h42, 32'd15, 1'b1, 1'b0, CID);
      repeat (15) tick();                                 // N+17
      probe("os_zero", 14'h42, 32'd0, 1'b1, 1'b0, CID);
      tick();                                             // N+18
      set_wr(14'h44, 32'h1, 32'h1);
      probe("os_ti", 14'h42, 32'hFFFF_FFFF, 1'b1, 1'b1, CID);
      tick_w();                                           // N+19
      probe("os_clr", 14'h42, 32'hFFFF_FFFF, 1'b1, 1'b0, CID);
      repeat (6) tick();
      probe("os_hold", 14'h42, 32'hFFFF_FFFF, 1'b1, 1'b0, CID);
      tick();
      probe("tcfg_rd", 14'h41, 32'h11, 1'b1, 1'b0, CID);
      tick();

      // Periodic, InitVal=2
      set_wr(14'h41, 32'hFFFF_FFFF, 32'h0B);
      tick_w();                                           // M+1
      probe("per_m1", 14'h42, 32'd8, 1'b1, 1'b0, CID);
      repeat (8) tick();                                  // M+9
      probe("per_m9", 14'h42, 32'd0, 1'b1, 1'b0, CID);
      tick();                                             // M+10
      set_wr(14'h44, 32'h1, 32'h1);
      probe("per_m10", 14'h42, 32'd8, 1'b1, 1'b1, CID);
      tick_w();                                           // M+11
      probe("per_m11", 14'h42, 32'd7, 1'b1, 1'b0, CID);
      repeat (8) tick();                                  // M+19
      set_wr(14'h44, 32'h1, 32'h1);
      probe("per_m19", 14'h42, 32'd8, 1'b1, 1'b1, CID);
      tick_w();                                           // M+20
      probe("per_m20", 14'h42, 32'd7, 1'b1, 1'b0, CID);
      repeat (7) tick();                                  // M+27
      set_wr(14'h44, 32'h1, 32'h1);
      probe("same_cyc", 14'h42, 32'd0, 1'b1, 1'b0, CID);
      tick_w();                                           // M+28
      probe("set_wins", 14'h42, 32'd8, 1'b1, 1'b1, CID);
      set_wr(14'h44, 32'h1, 32'h1);
      tick_w();                                           // M+29
      probe("clr_next", 14'h42, 32'd7, 1'b1, 1'b0, CID);

      // Masked write clears En only; TVAL reloads then holds
      set_wr(14'h41, 32'h1, 32'h0);
      tick_w();                                           // M+30
      probe("mask_tcfg", 14'h41, 32'h0A, 1'b1, 1'b0, CID);
      tick();
      probe("mask_tval", 14'h42, 32'd8, 1'b1, 1'b0, CID);
      repeat (3) tick();
      probe("mask_hold", 14'h42, 32'd8, 1'b1, 1'b0, CID);
      set_wr(14'h42, 32'hFFFF_FFFF, 32'h55);
      tick_w();
      probe("tval_ro", 14'h42, 32'd8, 1'b1, 1'b0, CID);
      tick();

      // TID masked merge
      set_wr(14'h40, 32'hFFFF_0000, 32'hABCD_0000);
      tick_w();
      probe("tid_merge", 14'h40, TID_NEW, 1'b1, 1'b0, TID_NEW);
      tick();

      // Periodic with InitVal=0: TI every cycle
      set_wr(14'h41, 32'hFFFF_FFFF, 32'h3);
      tick_w();                                           // K+1
      probe("p0_k1", 14'h42, 32'd0, 1'b1, 1'b0, TID_NEW);
      tick();                                             // K+2
      set_wr(14'h44, 32'h1, 32'h1);
      probe("p0_k2", 14'h42, 32'd0, 1'b1, 1'b1, TID_NEW);
      tick_w();                                           // K+3
      probe("p0_k3", 14'h41, 32'h3, 1'b1, 1'b1, TID_NEW);
      tick();

      // Asynchronous reset between edges
      resetn  = 1'b0;
      exp_cnt = 64'd0;
      probe("arst_tcfg", 14'h41, 32'h0, 1'b1, 1'b0, CID);
      tick();
      probe("arst_tval", 14'h42, 32'h0, 1'b1, 1'b0, CID);
      tick();
      resetn = 1'b1;
      repeat (5) tick();
      probe("post_rst", 14'h42, 32'h0, 1'b1, 1'b0, CID);
      tick();

      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL drain leftover=%0d required=0", exp_q.size());
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
